// File: rtl/clkdiv_prog_pkg.sv
// Shared definitions for the programmable clock divider feeding the glitch-free mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clkdiv_prog_pkg;

    // Divider run state; 2-bit encoding shared with the mux-side control logic.
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Smallest ratio that still gives at least one full input cycle per phase.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_prog_if.sv
// Control/observe bundle between the clock-control logic (master) and the divider (slave).
// Latency: n/a (wiring only).
// Backpressure: div_req is held until div_ack; busy shows an accepted change is pending.
//
// Signals:
//   enable  - run request, sampled every cycle
//   div_req - ratio-change request, held until div_ack
//   div_val - requested ratio, stable while div_req is high
//   div_ack - one-cycle pulse on the first cycle the new ratio is in effect
//   busy    - an accepted change has not yet been applied
//   cur_div - ratio currently in effect
//   clk_out - divided clock, straight from a flop
//   tick    - one-cycle pulse on the last input cycle of each output period
interface clkdiv_prog_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             div_req;
    logic [WIDTH-1:0] div_val;
    logic             div_ack;
    logic             busy;
    logic [WIDTH-1:0] cur_div;
    logic             clk_out;
    logic             tick;

    modport master (
        output enable, div_req, div_val,
        input  div_ack, busy, cur_div, clk_out, tick
    );

    modport slave (
        input  enable, div_req, div_val,
        output div_ack, busy, cur_div, clk_out, tick
    );
endinterface

// File: rtl/clkdiv_prog.sv
// Programmable integer divider: clk_out = clk / cur_div, changes applied only at period boundaries.
// Latency: clk_out high one edge after enable is sampled in STOP; ratio change acked within N_old+1 cycles.
// Backpressure: one change in flight; div_req is ignored while busy or during the div_ack cycle.
//
// Ports:
//   clk - input clock, all logic on posedge
//   rst - synchronous active-high reset
//   bus - clkdiv_prog_if slave modport (enable, ratio handshake, clk_out, tick)
module clkdiv_prog
    import clkdiv_prog_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_RST = 2
) (
    input  logic          clk,
    input  logic          rst,
    clkdiv_prog_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] val_clamped;
    logic [WIDTH:0]   thr_nxt;

    logic busy;
    logic busy_nxt;
    logic ack;
    logic ack_nxt;
    logic clk_out_q;
    logic clk_out_nxt;
    logic tick_q;
    logic tick_nxt;
    logic apply;

    logic running;
    logic wrap;
    logic accept;

    assign running = (state != ST_STOP);
    assign wrap    = running && (cnt == cur_div - WIDTH'(1));

    // The ack cycle is excluded so a requester that drops div_req one cycle
    // after seeing div_ack is not mistaken for a fresh request.
    assign accept  = bus.div_req && !busy && !ack;

    // Ratios below the minimum are silently raised rather than rejected.
    assign val_clamped = (bus.div_val < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : bus.div_val;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP:  if (bus.enable)  state_nxt = ST_RUN;
            // Dropping enable always drains, even on a wrap cycle, so a ratio
            // applied at that wrap still gets one full period.
            ST_RUN:   if (!bus.enable) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.enable) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_STOP;
                end
            end
            default:  state_nxt = ST_STOP;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        apply    = 1'b0;
        div_nxt  = cur_div;
        pend_nxt = pend;
        busy_nxt = busy;

        if (accept) begin
            pend_nxt = val_clamped;
        end

        if (running) begin
            // Running: only a wrap may change the ratio.
            if (wrap && busy) begin
                apply   = 1'b1;
                div_nxt = pend;
            end
        end else if (busy) begin
            // Accepted on the last drain cycle; nothing is running, apply now.
            apply   = 1'b1;
            div_nxt = pend;
        end else if (accept) begin
            // Stopped: bypass pend so a simultaneous start uses the new ratio.
            apply   = 1'b1;
            div_nxt = val_clamped;
        end

        if (apply) begin
            busy_nxt = 1'b0;
        end else if (accept) begin
            busy_nxt = 1'b1;
        end

        ack_nxt = apply;

        if (state_nxt == ST_STOP || !running || wrap) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + WIDTH'(1);
        end

        // ceil(N/2) in WIDTH+1 bits so N = 2^WIDTH-1 does not overflow.
        thr_nxt     = ({1'b0, div_nxt} + (WIDTH+1)'(1)) >> 1;
        clk_out_nxt = (state_nxt != ST_STOP) && ({1'b0, cnt_nxt} < thr_nxt);
        tick_nxt    = (state_nxt != ST_STOP) && (cnt_nxt == div_nxt - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cur_div   <= WIDTH'(DIV_RST);
            pend      <= WIDTH'(DIV_RST);
            busy      <= 1'b0;
            ack       <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            cur_div   <= div_nxt;
            pend      <= pend_nxt;
            busy      <= busy_nxt;
            ack       <= ack_nxt;
            clk_out_q <= clk_out_nxt;
            tick_q    <= tick_nxt;
        end
    end

    // clk_out is a bare flop output; nothing sits between it and the port.
    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack;
    assign bus.busy    = busy;
    assign bus.cur_div = cur_div;

endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Programmable integer clock divider producing a registered, glitch-free divided clock that feeds the `clkb` input of the glitch-free clock mux stage. It divides its single input clock by a runtime-programmable ratio N ≥ 2 and applies ratio changes and stop requests only at period boundaries, so no runt pulse ever reaches the mux. A one-cycle `tick` marks the last input cycle of each output period for the control logic.

## Interface
- `WIDTH`, 8: width of the divide ratio.
- `DIV_RST`, 2: ratio loaded at reset; must be in 2..2^WIDTH-1.
- `clk` input 1: input clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run request; sampled every cycle.
- `div_req` input 1: ratio-change request; held high until `div_ack`.
- `div_val` input WIDTH: requested ratio; stable while `div_req` is high.
- `div_ack` output 1: one-cycle pulse when the new ratio takes effect.
- `busy` output 1: a change has been accepted and is pending.
- `cur_div` output WIDTH: ratio currently in effect.
- `clk_out` output 1: divided clock, driven directly from a flop.
- `tick` output 1: one-cycle pulse on the last input cycle of each output period.

## Operation
- One clock domain (`clk`); synchronous, active-high reset `rst`.
- State machine: STOP, RUN, DRAIN.
  - STOP: `cnt` = 0, `clk_out` = 0. `enable` = 1 moves to RUN.
  - RUN: `cnt` counts 0..N-1 and wraps.
    - `clk_out` is high while `cnt` < ceil(N/2) and low otherwise.
    - Even N gives 50% duty; odd N gives high (N+1)/2 cycles, low (N-1)/2 cycles.
    - `enable` = 0 moves to DRAIN.
  - DRAIN: finishes the current period.
    - At the wrap, goes to STOP if `enable` is still 0.
    - If `enable` returned to 1, stays in RUN without a gap.
- Ratio request acceptance:
  - A request is accepted when `div_req` = 1 and `busy` = 0. `div_val` is captured into `pend` on that cycle.
  - Clamp: `div_val` < 2 is loaded as 2. Values are never rejected.
- Ratio request application:
  - In RUN or DRAIN, `pend` is applied at the next wrap (cnt = N-1 → 0). `cur_div` updates and `div_ack` pulses on the first cycle of the new period.
  - In STOP, `pend` is applied on the cycle after acceptance.
- `busy` is high from the cycle after acceptance through the cycle before `div_ack`.
- After `div_ack`, the requester drops `div_req` within one cycle. A `div_req` still high one cycle after ack is treated as a new request.
- Simultaneous events:
  - `enable` rising together with acceptance from STOP: the first period uses the new ratio.
  - `enable` falling in the same cycle a pending ratio applies: the ratio is applied, then DRAIN runs for one full period at the new ratio.
- `tick` = 1 in RUN/DRAIN when `cnt` = `cur_div`-1. It is never asserted in STOP.
- Arithmetic: `cnt` is WIDTH bits. The threshold is (N+1)>>1, computed in WIDTH+1 bits to avoid overflow at N = 2^WIDTH-1.

## Timing
- Reset values (all asserted the cycle after `rst` is sampled high):
  - state STOP, `cnt` = 0, `pend` = `DIV_RST`.
  - `clk_out` = 0, `tick` = 0, `div_ack` = 0, `busy` = 0, `cur_div` = `DIV_RST`.
- Reset mid-period truncates the output immediately: `clk_out` goes low at the next edge. A pending request is discarded without ack.
- Start latency: `enable` sampled high in STOP → `clk_out` high on the next edge.
- Output period is exactly `cur_div` input cycles. Every high and low phase is at least 1 full `clk` cycle.
- Ratio change latency: at most N_old+1 cycles from acceptance to `div_ack`.

## Structure
- Shared clocks package holds the state encoding (STOP/RUN/DRAIN, 2 bits) and the minimum-ratio constant (2). The mux stage's package already lives there.
- Single module, no sub-module. The counter/compare datapath is small enough to stay inline.
- `clk_out` comes straight from a flop. There must be no logic between that flop and the port.

## Test plan
- Reset, then `enable`=1 with `DIV_RST`=2 → `clk_out` toggles every cycle; `tick` fires every 2nd cycle; `cur_div`=2.
- Request `div_val`=5 while running at N=4 → `busy` high; `div_ack` on the first cycle after the N=4 wrap; then 3 high / 2 low; `tick` every 5 cycles.
- `div_val`=0 and `div_val`=1 → `cur_div`=2; output matches the N=2 case.
- `enable` dropped at `cnt`=1 of N=6 → period completes (3 high, 3 low), then `clk_out` stays 0 and `tick` stays silent. Re-raising `enable` during DRAIN → no gap between periods.
- `div_val`=255 with `WIDTH`=8 → 128 high / 127 low; no overflow.
- `rst` asserted mid-high phase with a request pending → next edge gives `clk_out`=0, `busy`=0, `cur_div`=`DIV_RST`, no `div_ack`.
